btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 126 ++++++++++++
 tb/tb_btn_debounce.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: two-flop synchronizer, four-state debounce FSM,
// registered press / release / long-press pulses and a hold level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES   = 5_000_000,
  parameter int LONG_PRESS_CYCLES = 250_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 ||
      LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_param
    $error("btn_debounce: illegal DEBOUNCE/LONG_PRESS parameters");
  end

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            long_q, long_d;
  logic            held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (!sync2_q) begin
          state_d   = PRESS_PEND;
          deb_cnt_d = '0;
        end
      end
      PRESS_PEND: begin
        if (sync2_q) begin
          state_d = RELEASED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (hold_cnt_q != HOLD_MAX)
          hold_cnt_d = hold_cnt_q + HW'(1);
        if (sync2_q) begin
          state_d   = RELEASE_PEND;
          deb_cnt_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (hold_cnt_q != HOLD_MAX)
          hold_cnt_d = hold_cnt_q + HW'(1);
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = RELEASED;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Release wins over a coincident long-press so pulses stay exclusive
  always_comb begin
    held    = (state_q == PRESSED) || (state_q == RELEASE_PEND);
    press_d = (state_q == PRESS_PEND) && (state_d == PRESSED);
    rel_d   = (state_q == RELEASE_PEND) && (state_d == RELEASED);
    long_d  = held && !rel_d &&
              (hold_cnt_d == LONG_LAST) && (hold_cnt_q != LONG_LAST);
  end

  assign hold       = held;
  assign btn_clean  = ~held;
  assign press      = press_q;
  assign release_p  = rel_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_clean, press, release_p, long_press, hold;

  btn_debounce #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .press     (press),
    .release_p (release_p),
    .long_press(long_press),
    .hold      (hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d",
               name, cyc, act, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every pulse seen on the outputs is matched against the queue
  always @(negedge clk) begin
    int   k;
    exp_t e;
    if (press || release_p || long_press) begin
      k = press ? K_PRESS : (release_p ? K_REL : K_LONG);
      if ((int'(press) + int'(release_p) + int'(long_press)) > 1) begin
        n_chk++;
        n_err++;
        $display("FAIL pulse_exclusive at cycle %0d: p=%0b r=%0b l=%0b",
                 cyc, press, release_p, long_press);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse kind %0d at cycle %0d, none expected",
                 k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc) begin
          n_err++;
          $display("FAIL pulse got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                   k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  int c;

  initial begin
    reset   = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_btn_clean", int'(btn_clean), 1);
    chk("rst_hold", int'(hold), 0);
    chk("rst_press", int'(press), 0);
    chk("rst_release", int'(release_p), 0);
    chk("rst_long", int'(long_press), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press, held 10 cycles
    c = cyc;
    btn_raw = 1'b0;
    push(K_PRESS, c + 7);
    wait_to(c + 6);
    chk("clean_pre_btn", int'(btn_clean), 1);
    wait_to(c + 7);
    chk("clean_btn", int'(btn_clean), 0);
    chk("clean_hold", int'(hold), 1);
    wait_to(c + 10);
    btn_raw = 1'b1;
    push(K_REL, c + 17);
    wait_to(c + 16);
    chk("clean_rel_pre", int'(btn_clean), 0);
    wait_to(c + 17);
    chk("clean_rel_btn", int'(btn_clean), 1);
    chk("clean_rel_hold", int'(hold), 0);
    wait_to(c + 30);

    // Bounce every 2 cycles for 12 cycles
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_to(c + 2 * (i + 1));
      chk("bounce_btn", int'(btn_clean), 1);
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bounce_settle", int'(btn_clean), 1);
    end
    wait_to(c + 25);

    // Long press held 40 cycles
    c = cyc;
    btn_raw = 1'b0;
    push(K_PRESS, c + 7);
    push(K_LONG, c + 26);
    wait_to(c + 40);
    btn_raw = 1'b1;
    push(K_REL, c + 47);
    wait_to(c + 46);
    chk("long_hold_lvl", int'(hold), 1);
    wait_to(c + 47);
    chk("long_rel_btn", int'(btn_clean), 1);
    wait_to(c + 60);

    // Release glitch of 2 cycles during PRESSED
    c = cyc;
    btn_raw = 1'b0;
    push(K_PRESS, c + 7);
    wait_to(c + 10);
    btn_raw = 1'b1;
    wait_to(c + 12);
    btn_raw = 1'b0;
    push(K_LONG, c + 26);
    for (int t = 13; t <= 20; t++) begin
      wait_to(c + t);
      chk("glitch_btn", int'(btn_clean), 0);
    end
    wait_to(c + 30);
    btn_raw = 1'b1;
    push(K_REL, c + 37);
    wait_to(c + 50);

    // Reset mid-press, button still low across reset release
    c = cyc;
    btn_raw = 1'b0;
    push(K_PRESS, c + 7);
    wait_to(c + 12);
    chk("mid_btn_pre", int'(btn_clean), 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_btn", int'(btn_clean), 1);
    chk("mid_rst_hold", int'(hold), 0);
    chk("mid_rst_pulses", int'(press | release_p | long_press), 0);
    wait_to(c + 14);
    reset = 1'b1;
    push(K_PRESS, c + 21);
    push(K_LONG, c + 40);
    wait_to(c + 20);
    chk("mid_repress_pre", int'(btn_clean), 1);
    wait_to(c + 21);
    chk("mid_repress_btn", int'(btn_clean), 0);
    wait_to(c + 45);
    btn_raw = 1'b1;
    push(K_REL, c + 52);
    wait_to(c + 65);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
